// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the instruction cache
package cpu_types_pkg;
   localparam int WORD_W    = 32;
   localparam int ITAG_W    = 26;
   localparam int IIDX_W    = 3;
   localparam int IBLK_W    = 1;
   localparam int IBYT_W    = 2;
   localparam int IBLKWORDS = 2;

   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      logic [ITAG_W-1:0] tag;
      logic [IIDX_W-1:0] idx;
      logic [IBLK_W-1:0] blkoff;
      logic [IBYT_W-1:0] bytoff;
   } icachef_t;

   typedef struct packed {
      logic                  valid;
      logic [ITAG_W-1:0]     tag;
      word_t [IBLKWORDS-1:0] data;
   } icache_frame_t;

   typedef enum logic [1:0] {IDLE, FETCH0, FETCH1} icache_state_t;
endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch port and memory instruction port of the icache
interface icache_if;
   import cpu_types_pkg::*;

   logic  imemREN;
   word_t imemaddr;
   logic  ihit;
   word_t imemload;
   logic  iREN;
   word_t iaddr;
   logic  iwait;
   word_t iload;

   modport slave (
      input  imemREN, imemaddr, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

   modport master (
      output imemREN, imemaddr, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped icache, 8 frames of 2-word blocks
// Combinational hits; misses run a two-beat refill from the latched miss address.
module icache
   import cpu_types_pkg::*;
#(
   parameter int NSETS    = 8,
   parameter int BLKWORDS = 2
) (
   input logic     CLK,
   input logic     nRST,
   icache_if.slave cif
);
   localparam logic [IBLK_W-1:0] FIRST_WORD = '0;
   localparam logic [IBLK_W-1:0] LAST_WORD  = IBLK_W'(BLKWORDS - 1);

   icache_frame_t     frames [NSETS];
   icache_state_t     state, next_state;
   logic [ITAG_W-1:0] miss_tag;
   logic [IIDX_W-1:0] miss_idx;
   icachef_t          addr;
   logic              hit, start_miss, fill0, fill1;
   logic              unused_bytoff;

   assign addr          = icachef_t'(cif.imemaddr);
   assign unused_bytoff = ^addr.bytoff;

   // Hits are suppressed during a refill so the fetch port never sees a half-written frame.
   assign hit = cif.imemREN && frames[addr.idx].valid &&
                (frames[addr.idx].tag == addr.tag) && (state == IDLE);
   assign cif.ihit     = hit;
   assign cif.imemload = hit ? frames[addr.idx].data[addr.blkoff] : '0;

   always_comb begin
      next_state = state;
      cif.iREN   = 1'b0;
      cif.iaddr  = '0;
      start_miss = 1'b0;
      fill0      = 1'b0;
      fill1      = 1'b0;
      unique case (state)
         IDLE: begin
            if (cif.imemREN && !hit) begin
               start_miss = 1'b1;
               next_state = FETCH0;
            end
         end
         FETCH0: begin
            cif.iREN  = 1'b1;
            cif.iaddr = {miss_tag, miss_idx, FIRST_WORD, 2'b00};
            if (!cif.iwait) begin
               fill0      = 1'b1;
               next_state = FETCH1;
            end
         end
         FETCH1: begin
            cif.iREN  = 1'b1;
            cif.iaddr = {miss_tag, miss_idx, LAST_WORD, 2'b00};
            if (!cif.iwait) begin
               fill1      = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state    <= IDLE;
         miss_tag <= '0;
         miss_idx <= '0;
         for (int i = 0; i < NSETS; i++) frames[i] <= '0;
      end else begin
         state <= next_state;
         if (start_miss) begin
            miss_tag <= addr.tag;
            miss_idx <= addr.idx;
         end
         if (fill0) frames[miss_idx].data[FIRST_WORD] <= cif.iload;
         // Tag and valid land with the last beat, so the old block stays intact until then.
         if (fill1) begin
            frames[miss_idx].data[LAST_WORD] <= cif.iload;
            frames[miss_idx].tag             <= miss_tag;
            frames[miss_idx].valid           <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed, table-driven bench for icache
module tb_icache;
   import cpu_types_pkg::*;

   typedef struct {
      logic        ren;
      logic [31:0] addr;
      logic        ihit;
      logic [31:0] load;
      logic        iren;
      logic [31:0] iaddr;
   } vec_t;

   logic     CLK = 1'b0;
   logic     nRST;
   icache_if bus ();
   int       n_checks = 0;
   int       n_pass   = 0;
   int       wait_cycles = 0;
   int       wcnt = 0;
   vec_t     vecs [21];

   icache #(.NSETS(8), .BLKWORDS(2)) dut (.CLK(CLK), .nRST(nRST), .cif(bus.slave));

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h2001_0005;
         32'h0000_0004: return 32'h2002_0007;
         default:       return 32'h1000_0000 | a;
      endcase
   endfunction

   // Memory model: each beat stalls wait_cycles cycles before data is returned.
   assign bus.iwait = bus.iREN && (wcnt < wait_cycles);
   assign bus.iload = bus.iREN ? mem_word(bus.iaddr) : 32'h0;

   always @(posedge CLK) begin
      if (!nRST) wcnt <= 0;
      else if (bus.iREN) wcnt <= bus.iwait ? wcnt + 1 : 0;
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic apply(vec_t v, string tag);
      bus.imemREN  = v.ren;
      bus.imemaddr = v.addr;
      @(negedge CLK);
      chk({tag, " ihit"},     32'(bus.ihit),  32'(v.ihit));
      chk({tag, " imemload"}, bus.imemload,   v.load);
      chk({tag, " iREN"},     32'(bus.iREN),  32'(v.iren));
      chk({tag, " iaddr"},    bus.iaddr,      v.iaddr);
      @(posedge CLK);
      #2;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h00, 1'b0, 32'h0,         1'b0, 32'h00};
      vecs[1]  = '{1'b1, 32'h00, 1'b0, 32'h0,         1'b1, 32'h00};
      vecs[2]  = '{1'b1, 32'h00, 1'b0, 32'h0,         1'b1, 32'h04};
      vecs[3]  = '{1'b1, 32'h00, 1'b1, 32'h2001_0005, 1'b0, 32'h00};
      vecs[4]  = '{1'b1, 32'h04, 1'b1, 32'h2002_0007, 1'b0, 32'h00};
      vecs[5]  = '{1'b0, 32'h00, 1'b0, 32'h0,         1'b0, 32'h00};
      vecs[6]  = '{1'b0, 32'h00, 1'b0, 32'h0,         1'b0, 32'h00};
      vecs[7]  = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b0, 32'h00};
      vecs[8]  = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h40};
      vecs[9]  = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h44};
      vecs[10] = '{1'b1, 32'h40, 1'b1, 32'h1000_0040, 1'b0, 32'h00};
      vecs[11] = '{1'b1, 32'h44, 1'b1, 32'h1000_0044, 1'b0, 32'h00};
      vecs[12] = '{1'b1, 32'h00, 1'b0, 32'h0,         1'b0, 32'h00};
      vecs[13] = '{1'b1, 32'h00, 1'b0, 32'h0,         1'b1, 32'h00};
      vecs[14] = '{1'b1, 32'h00, 1'b0, 32'h0,         1'b1, 32'h04};
      vecs[15] = '{1'b1, 32'h00, 1'b1, 32'h2001_0005, 1'b0, 32'h00};
      vecs[16] = '{1'b1, 32'h08, 1'b0, 32'h0,         1'b0, 32'h00};
      vecs[17] = '{1'b1, 32'h00, 1'b0, 32'h0,         1'b1, 32'h08};
      vecs[18] = '{1'b1, 32'h00, 1'b0, 32'h0,         1'b1, 32'h0C};
      vecs[19] = '{1'b1, 32'h00, 1'b1, 32'h2001_0005, 1'b0, 32'h00};
      vecs[20] = '{1'b1, 32'h0C, 1'b1, 32'h1000_000C, 1'b0, 32'h00};

      nRST         = 1'b0;
      bus.imemREN  = 1'b0;
      bus.imemaddr = 32'h0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("reset ihit",     32'(bus.ihit), 32'h0);
      chk("reset imemload", bus.imemload,  32'h0);
      chk("reset iREN",     32'(bus.iREN), 32'h0);
      chk("reset iaddr",    bus.iaddr,     32'h0);
      @(posedge CLK);
      #2;
      nRST = 1'b1;

      for (int k = 0; k < 21; k++) apply(vecs[k], $sformatf("vec%0d", k));

      // Wait states: 4 stall cycles per beat, ihit 11 cycles after the miss.
      wait_cycles  = 4;
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h10;
      for (int c = 0; c <= 11; c++) begin
         @(negedge CLK);
         chk($sformatf("wait c%0d ihit", c), 32'(bus.ihit), 32'(c == 11));
         chk($sformatf("wait c%0d iREN", c), 32'(bus.iREN), 32'(c >= 1 && c <= 10));
         chk($sformatf("wait c%0d iaddr", c), bus.iaddr,
             (c >= 1 && c <= 5) ? 32'h10 : (c >= 6 && c <= 10) ? 32'h14 : 32'h0);
         if (c == 11) chk("wait load", bus.imemload, 32'h1000_0010);
         @(posedge CLK);
         #2;
      end
      wait_cycles = 0;

      // Address change mid-refill: 0x80 completes, then 0x100 refills the same frame.
      apply('{1'b1, 32'h080, 1'b0, 32'h0, 1'b0, 32'h000}, "chg miss");
      apply('{1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h080}, "chg f0");
      apply('{1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h084}, "chg f1");
      chk("chg frame0 valid", 32'(dut.frames[0].valid), 32'h1);
      chk("chg frame0 tag",   32'(dut.frames[0].tag),   32'h2);
      apply('{1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h000}, "chg remiss");
      apply('{1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h100}, "chg2 f0");
      apply('{1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h104}, "chg2 f1");
      apply('{1'b1, 32'h100, 1'b1, 32'h1000_0100, 1'b0, 32'h0}, "chg2 hit");

      // Reset during FETCH1 aborts the refill; the address then refills fully.
      apply('{1'b1, 32'h18, 1'b0, 32'h0, 1'b0, 32'h00}, "rst miss");
      apply('{1'b1, 32'h18, 1'b0, 32'h0, 1'b1, 32'h18}, "rst f0");
      nRST = 1'b0;
      apply('{1'b1, 32'h18, 1'b0, 32'h0, 1'b1, 32'h1C}, "rst f1");
      nRST = 1'b1;
      chk("rst frame3 valid", 32'(dut.frames[3].valid), 32'h0);
      apply('{1'b1, 32'h18, 1'b0, 32'h0, 1'b0, 32'h00}, "rst after");
      apply('{1'b1, 32'h18, 1'b0, 32'h0, 1'b1, 32'h18}, "rst2 f0");
      apply('{1'b1, 32'h18, 1'b0, 32'h0, 1'b1, 32'h1C}, "rst2 f1");
      apply('{1'b1, 32'h18, 1'b1, 32'h1000_0018, 1'b0, 32'h00}, "rst2 hit");
      apply('{1'b1, 32'h00, 1'b0, 32'h0, 1'b0, 32'h00}, "rst cold0");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the pipelined datapath's fetch port (imemREN/imemaddr/imemload/ihit) and the memory controller's instruction port (iREN/iaddr/iload/iwait). It holds 8 frames of 2-word blocks. Hits return combinationally in the same cycle. A miss runs a two-beat block refill from memory, then the retried fetch hits. The datapath already gates ihit with pending data accesses, so the icache carries no knowledge of the data side.

## Interface
Parameters:
- NSETS, 8, number of frames (index width = log2(NSETS) = 3)
- BLKWORDS, 2, words per block (fixed at 2 for this revision)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  reset, synchronous, active-low
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  byte address of the fetch
- ihit  out  1  imemload is valid this cycle
- imemload  out  32  fetched instruction word
- iREN  out  1  memory read request
- iaddr  out  32  memory read byte address
- iwait  in  1  memory not ready; when low with iREN high, iload is valid this cycle
- iload  in  32  memory read data

## Operation
- Address split (byte address): [1:0] byte offset, ignored; [2] block offset; [5:3] index; [31:6] tag (26 bits).
- Frame state:
  - valid bit, one per frame.
  - 26-bit tag, one per frame.
  - two 32-bit data words, one per frame.
- Hit condition: imemREN && valid[idx] && tag[idx]==addr tag && state==IDLE.
  - On a hit, ihit=1 and imemload=data[idx][blkoff].
  - Otherwise ihit=0 and imemload=0.
- FSM states: IDLE, FETCH0, FETCH1.
  - IDLE:
    - iREN=0, iaddr=0.
    - If imemREN and no hit, latch miss tag/index into the refill registers and go to FETCH0.
    - Otherwise stay in IDLE.
  - FETCH0:
    - iREN=1, iaddr={miss tag, miss idx, 1'b0, 2'b00}.
    - When iwait=0, write iload to data[idx][0] and go to FETCH1.
    - Otherwise hold.
  - FETCH1:
    - iREN=1, iaddr={miss tag, miss idx, 1'b1, 2'b00}.
    - When iwait=0, write iload to data[idx][1], write tag[idx]=miss tag and valid[idx]=1, then go to IDLE.
- A refill always runs to completion using the latched miss address, even if imemREN drops or imemaddr changes mid-refill. The memory handshake is never abandoned.
- ihit is 0 throughout FETCH0/FETCH1, including fetches that would hit another frame.
- valid[idx] is not cleared at refill start. The old tag still mismatches the miss, and the frame is overwritten only on completion.
- After a refill, IDLE re-evaluates the current imemaddr. If it differs from the refilled block and misses, a new refill starts.

## Timing
- Hit latency: 0 cycles (combinational from imemaddr).
- Miss, zero-wait memory:
  - cycle 0: IDLE, miss detected.
  - cycle 1: FETCH0.
  - cycle 2: FETCH1.
  - cycle 3: IDLE, ihit=1.
  - Miss penalty = 3 + total iwait-high cycles.
- Reset (nRST low at an edge):
  - State=IDLE and all valid=0.
  - Miss refill registers=0.
  - Outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
  - Data/tag arrays are cleared to 0.
- Reset asserted during FETCH0/FETCH1 aborts the refill. No frame is marked valid. iREN is low from the next cycle.
- iwait is sampled only while iREN=1. iaddr is stable for the whole time iREN is high within a beat.

## Structure
- Shared package cpu_types_pkg holds:
  - word_t.
  - icachef_t, a packed struct {tag[25:0], idx[2:0], blkoff[0:0], bytoff[1:0]} for casting imemaddr.
  - icache_frame_t {valid, tag, data[2]}.
  - icache_state_t enum {IDLE, FETCH0, FETCH1}.
- Constants ITAG_W=26, IIDX_W=3, IBLK_W=1.
- Single module; no sub-module. The frame array is an array of icache_frame_t inside icache.

## Test plan
- Cold miss with iwait=0 and iload driven = 0x20010005 then 0x20020007:
  - Reset, then imemREN=1, imemaddr=0x00000000.
  - iREN high for cycles 1–2, with iaddr 0x00 then 0x04.
  - Cycle 3: ihit=1, imemload=0x20010005.
  - imemaddr=0x04 then hits immediately with 0x20020007.
- Wait states: iwait=1 for 4 cycles on each beat.
  - iaddr holds per beat and the state does not advance.
  - ihit rises 11 cycles after the miss.
- Conflict eviction:
  - Fill 0x00000000, then fetch 0x00000040 (same idx 0, different tag) → refill of 0x40/0x44.
  - Refetch 0x00000000 → misses again.
- Address change mid-refill: imemaddr switches from 0x80 to 0x100 during FETCH0.
  - Refill completes for 0x80/0x84 only.
  - Then a new refill starts for 0x100.
  - Frame 0 (idx of 0x80) is valid with tag 0x2.
- Reset mid-refill: nRST low during FETCH1.
  - Next cycle iREN=0 and ihit=0.
  - The same address then misses and performs the full 2-beat refill.
- imemREN=0 with a valid matching address → ihit=0, imemload=0, no refill.
